dmem_responder: RTL and testbench
=================================

# dmem_responder

Banked data-memory responder at the memory end of the data-cache/controller channels. It accepts per-channel read and write requests on the valid/ready channel interface that the data cache drives toward memory, and services them from an internal multi-bank array. Each request gets a single-cycle ready pulse, returned with data for reads. It is the memory-side counterpart used in simulation and on-chip builds.

## Interface

Parameters:
- ADDR_BITS, 8: address width; array depth is 2^ADDR_BITS words.
- DATA_BITS, 8: word width.
- NUM_CHANNELS, 8: number of independent request channels.
- NUM_BANKS, 2: power of two; bank = address[log2(NUM_BANKS)-1:0].
- LATENCY, 2: cycles from grant to ready pulse; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_read_valid  in  [NUM_CHANNELS]  read request per channel, held until ready.
- mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address.
- mem_read_ready  out  [NUM_CHANNELS]  one-cycle read completion pulse.
- mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, valid when ready is high; held afterwards.
- mem_write_valid  in  [NUM_CHANNELS]  write request per channel, held until ready.
- mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address.
- mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data.
- mem_write_ready  out  [NUM_CHANNELS]  one-cycle write completion pulse.

## Operation

- Reset: all ready outputs are 0; all read_data is 0; every channel is IDLE; arbiter pointers are 0; array contents are cleared to 0.
- Per-channel FSM:
  - IDLE: a request is pending if read_valid or write_valid is high. If both are high, the read is serviced first and the write stays pending.
  - IDLE to BUSY: on a bank grant. Address, data and operation are latched at the grant edge.
  - BUSY: a counter runs LATENCY-1 cycles, then the channel moves to RESPOND.
  - RESPOND: the matching ready is high for exactly one cycle, then the channel moves to DROP.
  - DROP: the channel waits until the valid for the completed operation is low, then returns to IDLE. This prevents a still-high valid from being re-served.
- Array access happens in the grant cycle:
  - Write: commits to the array at the grant edge.
  - Read: data is captured from the array at the grant edge into a per-channel data register.
  - The data register drives mem_read_data at RESPOND and holds until the next read grant on that channel.
- Bank arbitration:
  - Each bank grants at most one channel per cycle.
  - Each bank has a round-robin pointer. The granted channel is the first requesting IDLE channel at or after the pointer.
  - After a grant, the pointer moves to the granted channel + 1, mod NUM_CHANNELS.
  - Channels targeting different banks are granted in the same cycle.
- Ordering:
  - Same address in the same cycle: requests serialize in grant order.
  - A read granted after a write sees the written value.
  - A read granted in the same cycle as a write cannot occur, because both would target one bank.
- Addresses are used in full; no width conversion.

## Timing

- Uncontended request, valid rising in cycle T: grant at the end of T, ready high in cycle T+LATENCY.
- Each cycle lost to arbitration adds exactly one cycle.
- Initiator drops valid on the edge where it samples ready: the channel sees valid low in DROP, and a new request is accepted from cycle T+LATENCY+2 at the earliest.
- Valid held high past RESPOND: the channel stays in DROP and emits no second ready.
- Reset mid-operation: in-flight requests are discarded with no ready pulse. Writes already granted remain only if reset is not asserted (reset clears the array).
- Valid deasserted before ready (protocol violation): the request is still completed.

## Structure

- Package dmem_pkg:
  - channel state enum: IDLE, BUSY, RESPOND, DROP.
  - op enum: OP_READ, OP_WRITE.
  - bank-index width constant.
- Sub-module dmem_bank: one per bank, instantiated NUM_BANKS times. Each instance holds:
  - a single-port array of depth 2^ADDR_BITS/NUM_BANKS;
  - the round-robin arbiter;
  - grant outputs.
- The top level holds the per-channel FSMs, latency counters and data registers.

## Test plan

- Single write then read, LATENCY=2: write addr 0x10 data 0xA5 on ch0. Required: write_ready pulse 2 cycles after valid. Then read 0x10: read_ready 2 cycles later with data 0xA5.
- Bank conflict: ch0 reads 0x02 and ch1 reads 0x04 (both bank 0) in the same cycle. Required: ch0 ready at T+2, ch1 at T+3. A following conflict grants ch1 first (pointer rotation).
- Parallel banks: ch0 reads 0x02 and ch1 reads 0x03 in the same cycle. Required: both ready at T+2.
- Held valid: ch2 keeps read_valid high for 5 cycles after ready. Required: exactly one ready pulse, and no new grant until valid drops.
- Read and write both high on ch3 (read 0x20, write 0x20 = 0x3C, after reset). Required: read completes first with 0x00, then the write completes.
- Reset in BUSY: assert reset one cycle after grant. Required: no ready pulse, all outputs 0 the next cycle, and a subsequent read of any address returns 0x00.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND,
        DROP
    } chan_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_BANKS = 2;
    localparam int BANK_IDX_W    = idx_w(DEF_NUM_BANKS);

endpackage

// File: rtl/dmem_bank.sv
// One memory bank: round-robin channel arbiter plus a single-port word array.
// The array is accessed only by the granted channel in the grant cycle.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int LOC_W        = 7,
    parameter int DATA_BITS    = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 req,
    input  logic [NUM_CHANNELS-1:0]                 is_write,
    input  logic [NUM_CHANNELS-1:0][LOC_W-1:0]      loc,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  wdata,
    output logic [NUM_CHANNELS-1:0]                 grant,
    output logic [DATA_BITS-1:0]                    rdata
);

    localparam int DEPTH = 1 << LOC_W;
    localparam int CH_W  = idx_w(NUM_CHANNELS);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [CH_W-1:0]      ptr_q;
    logic [CH_W-1:0]      gidx;
    logic                 found;

    // Pick the first requester at or after the pointer; expose its read word.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx   = '0;
        found = 1'b0;
        gidx  = ptr_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = CH_W'((int'(ptr_q) + i) % NUM_CHANNELS);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        grant = '0;
        if (found) grant[gidx] = 1'b1;
        rdata = mem[loc[gidx]];
    end

    // Commit granted writes and rotate the pointer past the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int a = 0; a < DEPTH; a++) mem[LOC_W'(a)] <= '0;
        end else if (found) begin
            if (is_write[gidx]) mem[loc[gidx]] <= wdata[gidx];
            ptr_q <= (gidx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Banked data-memory responder: per-channel request FSMs feeding one arbiter
// per bank. Bank = low address bits; NUM_BANKS must be a power of two >= 2.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int LATENCY      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int BANK_W = idx_w(NUM_BANKS);
    localparam int LOC_W  = ADDR_BITS - BANK_W;
    localparam int CNT_W  = idx_w(LATENCY);

    logic [NUM_CHANNELS-1:0]                 req_vld;
    logic [NUM_CHANNELS-1:0]                 req_wr;
    logic [NUM_CHANNELS-1:0][BANK_W-1:0]     req_bank;
    logic [NUM_CHANNELS-1:0][LOC_W-1:0]      req_loc;
    logic [NUM_CHANNELS-1:0]                 granted;
    logic [NUM_BANKS-1:0][NUM_CHANNELS-1:0]  bank_req;
    logic [NUM_BANKS-1:0][NUM_CHANNELS-1:0]  bank_gnt;
    logic [NUM_BANKS-1:0][DATA_BITS-1:0]     bank_rdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_route
            assign bank_req[b][c] = req_vld[c] && (req_bank[c] == BANK_W'(b));
        end

        dmem_bank #(
            .NUM_CHANNELS (NUM_CHANNELS),
            .LOC_W        (LOC_W),
            .DATA_BITS    (DATA_BITS)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .req      (bank_req[b]),
            .is_write (req_wr),
            .loc      (req_loc),
            .wdata    (mem_write_data),
            .grant    (bank_gnt[b]),
            .rdata    (bank_rdata[b])
        );
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        chan_state_e           state_q, state_d;
        op_e                   op_q, op_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic [DATA_BITS-1:0]  data_q;
        logic [ADDR_BITS-1:0]  addr;

        // A pending read always wins over a pending write on the same channel.
        assign addr        = mem_read_valid[c] ? mem_read_address[c] : mem_write_address[c];
        assign req_vld[c]  = (state_q == IDLE) && (mem_read_valid[c] || mem_write_valid[c]);
        assign req_wr[c]   = !mem_read_valid[c];
        assign req_bank[c] = addr[BANK_W-1:0];
        assign req_loc[c]  = addr[ADDR_BITS-1:BANK_W];
        assign granted[c]  = bank_gnt[req_bank[c]][c];

        // Channel state, latched op and latency counter.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                op_q    <= OP_READ;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: grant -> wait LATENCY-1 cycles -> one ready cycle -> wait for valid low.
        always_comb begin
            state_d = state_q;
            op_d    = op_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (granted[c]) begin
                        op_d = req_wr[c] ? OP_WRITE : OP_READ;
                        if (LATENCY == 1) begin
                            state_d = RESPOND;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) state_d = RESPOND;
                    else                    cnt_d   = cnt_q - 1'b1;
                end
                RESPOND: state_d = DROP;
                DROP: begin
                    if ((op_q == OP_READ) ? !mem_read_valid[c] : !mem_write_valid[c])
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Read word is captured at the grant edge and held until the next read grant.
        always_ff @(posedge clk) begin
            if (reset)                       data_q <= '0;
            else if (granted[c] && !req_wr[c]) data_q <= bank_rdata[req_bank[c]];
        end

        assign mem_read_ready[c]  = (state_q == RESPOND) && (op_q == OP_READ);
        assign mem_write_ready[c] = (state_q == RESPOND) && (op_q == OP_WRITE);
        assign mem_read_data[c]   = data_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// request groups checked against an array/round-robin reference model.
module tb_dmem_responder;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rv, wv, rr, wrr;
    logic [7:0][7:0] raddr, waddr, wdata, rdata;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(8), .NUM_BANKS(2), .LATENCY(2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (raddr),
        .mem_read_ready    (rr),
        .mem_read_data     (rdata),
        .mem_write_valid   (wv),
        .mem_write_address (waddr),
        .mem_write_data    (wdata),
        .mem_write_ready   (wrr)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] ref_mem [256];
    int         ref_ptr [2];

    // Current request group and results
    bit         g_act [8];
    bit         g_wr  [8];
    logic [7:0] g_addr[8];
    logic [7:0] g_data[8];
    int         g_lat [8];
    logic [7:0] g_rd  [8];
    int         e_lat [8];
    logic [7:0] e_rd  [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
        ref_ptr[0] = 0;
        ref_ptr[1] = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; rv = '0; wv = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic clear_group();
        for (int c = 0; c < 8; c++) begin
            g_act[c] = 0; g_wr[c] = 0; g_addr[c] = '0; g_data[c] = '0;
            e_lat[c] = -1; e_rd[c] = '0;
        end
    endtask

    // Simultaneous requests on idle channels: per bank, channels are served one
    // per cycle in cyclic order starting at the bank pointer.
    task automatic model_group();
        for (int b = 0; b < 2; b++) begin
            int k, last;
            k = 0; last = -1;
            for (int i = 0; i < 8; i++) begin
                int c;
                c = (ref_ptr[b] + i) % 8;
                if (g_act[c] && (int'(g_addr[c]) % 2 == b)) begin
                    e_lat[c] = 2 + k;
                    k++;
                    if (g_wr[c]) ref_mem[g_addr[c]] = g_data[c];
                    else         e_rd[c] = ref_mem[g_addr[c]];
                    last = c;
                end
            end
            if (last >= 0) ref_ptr[b] = (last + 1) % 8;
        end
    endtask

    task automatic run_group(input string tag);
        int cyc, spur;
        bit done[8], newly[8], all_done;
        model_group();
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            done[c] = 0; g_lat[c] = -1; g_rd[c] = 'x;
            if (g_act[c]) begin
                if (g_wr[c]) begin wv[c] = 1'b1; waddr[c] = g_addr[c]; wdata[c] = g_data[c]; end
                else begin rv[c] = 1'b1; raddr[c] = g_addr[c]; end
            end
        end
        cyc = 0; spur = 0; all_done = 0;
        while (!all_done && cyc < 40) begin
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                newly[c] = 0;
                if (rr[c] || wrr[c]) begin
                    if (g_act[c] && !done[c] &&
                        (g_wr[c] ? (wrr[c] && !rr[c]) : (rr[c] && !wrr[c]))) begin
                        newly[c] = 1; done[c] = 1; g_lat[c] = cyc; g_rd[c] = rdata[c];
                    end else begin
                        spur++;
                    end
                end
            end
            @(posedge clk); #1;
            for (int c = 0; c < 8; c++) if (newly[c]) begin rv[c] = 1'b0; wv[c] = 1'b0; end
            cyc++;
            all_done = 1;
            for (int c = 0; c < 8; c++) if (g_act[c] && !done[c]) all_done = 0;
        end
        for (int c = 0; c < 8; c++) begin
            if (g_act[c]) begin
                check($sformatf("%s lat ch%0d", tag, c), 64'(g_lat[c]), 64'(e_lat[c]));
                if (!g_wr[c]) check($sformatf("%s data ch%0d", tag, c), 64'(g_rd[c]), 64'(e_rd[c]));
            end
        end
        check($sformatf("%s spurious ready", tag), 64'(spur), 64'd0);
    endtask

    task automatic held_valid_test();
        int cyc, lat, pulses;
        logic [7:0] d;
        clear_group();
        g_act[2] = 1; g_addr[2] = 8'h11;
        model_group();
        @(posedge clk); #1;
        rv[2] = 1'b1; raddr[2] = 8'h11;
        lat = -1; cyc = 0; d = '0;
        while (lat < 0 && cyc < 20) begin
            @(negedge clk);
            if (rr[2]) begin lat = cyc; d = rdata[2]; end
            cyc++;
        end
        check("held lat", 64'(lat), 64'd2);
        check("held data", 64'(d), 64'(e_rd[2]));
        check("held data const", 64'(d), 64'h6B);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rr[2]) pulses++;
        end
        check("held extra pulses", 64'(pulses), 64'd0);
        @(posedge clk); #1 rv[2] = 1'b0;
    endtask

    task automatic rw_same_test();
        int cyc, rlat, wlat;
        logic [7:0] d;
        @(posedge clk); #1;
        rv[3] = 1'b1; raddr[3] = 8'h20;
        wv[3] = 1'b1; waddr[3] = 8'h20; wdata[3] = 8'h3C;
        rlat = -1; wlat = -1; cyc = 0; d = 'x;
        while ((rlat < 0 || wlat < 0) && cyc < 40) begin
            @(negedge clk);
            if (rr[3] && rlat < 0) begin rlat = cyc; d = rdata[3]; end
            if (wrr[3] && wlat < 0) wlat = cyc;
            @(posedge clk); #1;
            if (rlat >= 0) rv[3] = 1'b0;
            if (wlat >= 0) wv[3] = 1'b0;
            cyc++;
        end
        // Two grants to ch3 on bank 0: read then write.
        ref_mem[8'h20] = 8'h3C;
        ref_ptr[0] = 4;
        check("rw read lat", 64'(rlat), 64'd2);
        check("rw read data", 64'(d), 64'h00);
        check("rw write lat", 64'(wlat), 64'd6);
    endtask

    task automatic reset_busy_test();
        int pulses;
        @(posedge clk); #1;
        wv[0] = 1'b1; waddr[0] = 8'h05; wdata[0] = 8'h77;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 begin reset = 1'b0; wv[0] = 1'b0; end
        model_clear();
        @(negedge clk);
        check("rstbusy rready", 64'(rr), 64'd0);
        check("rstbusy wready", 64'(wrr), 64'd0);
        check("rstbusy rdata", 64'(rdata), 64'd0);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rr != 0 || wrr != 0) pulses++;
        end
        check("rstbusy late ready", 64'(pulses), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        clear_group();
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rready", 64'(rr), 64'd0);
        check("reset wready", 64'(wrr), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);
        #1 reset = 1'b0;

        // Single write then read on ch0
        clear_group(); g_act[0] = 1; g_wr[0] = 1; g_addr[0] = 8'h10; g_data[0] = 8'hA5;
        run_group("wr10");
        check("wr10 lat const", 64'(g_lat[0]), 64'd2);
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h10;
        run_group("rd10");
        check("rd10 lat const", 64'(g_lat[0]), 64'd2);
        check("rd10 data const", 64'(g_rd[0]), 64'hA5);

        // Bank conflict from fresh pointers, then rotation
        apply_reset();
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h02; g_act[1] = 1; g_addr[1] = 8'h04;
        run_group("conf1");
        check("conf1 ch0 const", 64'(g_lat[0]), 64'd2);
        check("conf1 ch1 const", 64'(g_lat[1]), 64'd3);
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h06;
        run_group("solo0");
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h02; g_act[1] = 1; g_addr[1] = 8'h04;
        run_group("conf2");
        check("conf2 ch1 first", 64'(g_lat[1]), 64'd2);
        check("conf2 ch0 second", 64'(g_lat[0]), 64'd3);

        // Parallel banks
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h02; g_act[1] = 1; g_addr[1] = 8'h03;
        run_group("par");
        check("par ch0 const", 64'(g_lat[0]), 64'd2);
        check("par ch1 const", 64'(g_lat[1]), 64'd2);

        // Held valid on ch2
        clear_group(); g_act[2] = 1; g_wr[2] = 1; g_addr[2] = 8'h11; g_data[2] = 8'h6B;
        run_group("wr11");
        held_valid_test();
        clear_group(); g_act[2] = 1; g_addr[2] = 8'h11;
        run_group("reread11");

        // Read and write both pending on ch3
        apply_reset();
        rw_same_test();
        clear_group(); g_act[3] = 1; g_addr[3] = 8'h20;
        run_group("rd20");
        check("rd20 data const", 64'(g_rd[3]), 64'h3C);

        // Random groups over a narrow address range to force conflicts
        for (int n = 0; n < 40; n++) begin
            int cnt;
            clear_group();
            cnt = $urandom_range(1, 4);
            for (int j = 0; j < cnt; j++) begin
                int c;
                c = $urandom_range(0, 7);
                g_act[c]  = 1;
                g_wr[c]   = 1'($urandom_range(0, 1));
                g_addr[c] = 8'($urandom_range(0, 15));
                g_data[c] = 8'($urandom_range(0, 255));
            end
            run_group($sformatf("rand%0d", n));
        end

        // Reset while a write is in BUSY
        clear_group(); g_act[1] = 1; g_wr[1] = 1; g_addr[1] = 8'h09; g_data[1] = 8'h5A;
        run_group("wr09");
        clear_group(); g_act[1] = 1; g_addr[1] = 8'h09;
        run_group("rd09");
        reset_busy_test();
        clear_group(); g_act[0] = 1; g_addr[0] = 8'h05; g_act[1] = 1; g_addr[1] = 8'h09;
        run_group("postrst");
        check("postrst ch0 const", 64'(g_rd[0]), 64'h00);
        check("postrst ch1 const", 64'(g_rd[1]), 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
